// File: rtl/tick_rate_ctrl.sv
// Programmable rate controller: a reloading down-counter that emits one-cycle
// enable ticks and a divided square wave, with run/pause/idle/single-step control.
module tick_rate_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 49
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  output logic             tick,
  output logic             divout,
  output logic             running,
  output logic             paused,
  output logic [DIV_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] pend_reg;
  logic             pend_valid_reg;
  logic [DIV_W-1:0] count_reg;
  logic             tick_reg;
  logic             divout_reg;
  logic             running_reg;
  logic             paused_reg;

  // A divide value loaded while running only takes effect at the next period boundary.
  logic [DIV_W-1:0] reload_val;
  assign reload_val = pend_valid_reg ? pend_reg : div_reg;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      div_reg        <= DEF_DIV;
      pend_reg       <= DEF_DIV;
      pend_valid_reg <= 1'b0;
      count_reg      <= '0;
      tick_reg       <= 1'b0;
      divout_reg     <= 1'b0;
      running_reg    <= 1'b0;
      paused_reg     <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            div_reg        <= div_in;
            pend_valid_reg <= 1'b0;
          end
          if (start && !stop) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
            paused_reg  <= 1'b0;
            count_reg   <= load ? div_in : div_reg;
          end
        end

        RUN: begin
          if (stop) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
            paused_reg  <= 1'b1;
          end else if (count_reg == '0) begin
            tick_reg   <= 1'b1;
            divout_reg <= ~divout_reg;
            count_reg  <= reload_val;
            if (pend_valid_reg) begin
              div_reg <= pend_reg;
            end
          end else begin
            count_reg <= count_reg - 1'b1;
          end
          // A load on the reload edge stays pending for the following period.
          if (load) begin
            pend_reg       <= div_in;
            pend_valid_reg <= 1'b1;
          end else if (!stop && count_reg == '0) begin
            pend_valid_reg <= 1'b0;
          end
        end

        PAUSE: begin
          if (load) begin
            div_reg        <= div_in;
            pend_valid_reg <= 1'b0;
          end
          if (stop) begin
            state_reg   <= IDLE;
            running_reg <= 1'b0;
            paused_reg  <= 1'b0;
            count_reg   <= '0;
            divout_reg  <= 1'b0;
          end else if (start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
            paused_reg  <= 1'b0;
          end else if (step) begin
            tick_reg   <= 1'b1;
            divout_reg <= ~divout_reg;
            count_reg  <= div_reg;
          end
        end

        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
          paused_reg  <= 1'b0;
          count_reg   <= '0;
        end
      endcase
    end
  end

  assign tick    = tick_reg;
  assign divout  = divout_reg;
  assign running = running_reg;
  assign paused  = paused_reg;
  assign count   = count_reg;

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Scoreboard bench for tick_rate_ctrl: stimulus queues expected tick cycles,
// a negedge monitor pops and checks them as ticks appear.
module tb_tick_rate_ctrl;

  logic       hz100;
  logic       reset;
  logic       start;
  logic       stop;
  logic       step;
  logic       load;
  logic [7:0] div_in;
  logic       tick;
  logic       divout;
  logic       running;
  logic       paused;
  logic [7:0] count;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int c;
    bit dv;
  } exp_t;
  exp_t q[$];

  tick_rate_ctrl #(.DIV_W(8), .DEFAULT_DIV(49)) dut (
    .hz100  (hz100),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .step   (step),
    .load   (load),
    .div_in (div_in),
    .tick   (tick),
    .divout (divout),
    .running(running),
    .paused (paused),
    .count  (count)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;
  always @(posedge hz100) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_tick(input int c, input bit dv);
    exp_t e;
    e.c  = c;
    e.dv = dv;
    q.push_back(e);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge hz100);
  endtask

  // Called at a negedge; pulses the given inputs for exactly one rising edge.
  task automatic drive(input bit st, input bit sp, input bit stp, input bit ld, input logic [7:0] d);
    start  = st;
    stop   = sp;
    step   = stp;
    load   = ld;
    div_in = d;
    @(negedge hz100);
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
    load  = 1'b0;
  endtask

  task automatic wait_to(input int t);
    if (cyc > t) begin
      compared++;
      mismatched++;
      $display("FAIL sched: cyc %0d already past target %0d", cyc, t);
    end
    while (cyc < t) @(negedge hz100);
  endtask

  // Monitor: every tick must match the head of the queue in cycle and divout.
  always @(negedge hz100) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].c < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL tick_missing: got no tick expected one at cyc %0d (now %0d)", q[0].c, cyc);
        void'(q.pop_front());
      end
      if (tick === 1'b1) begin
        if (q.size() > 0 && q[0].c == cyc) begin
          $display("tick at cyc %0d divout=%0d", cyc, divout);
          chk("tick_divout", {31'd0, divout}, {31'd0, q[0].dv});
          void'(q.pop_front());
        end else begin
          compared++;
          mismatched++;
          $display("FAIL tick_unexpected: got tick expected none at cyc %0d", cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int seq[5];
    seq = '{3, 2, 1, 0, 3};
    reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0; div_in = 8'd0;
    nclk(2);
    chk("rst_count", count, 0);
    chk("rst_tick", tick, 0);
    chk("rst_divout", divout, 0);
    chk("rst_running", running, 0);
    chk("rst_paused", paused, 0);
    reset = 1'b0;
    nclk(1);

    // Default divide of 49: ticks every 50 cycles.
    s = cyc;
    exp_tick(s + 51, 1'b1);
    exp_tick(s + 101, 1'b0);
    exp_tick(s + 151, 1'b1);
    drive(1, 0, 0, 0, 8'd0);
    $display("start default div at cyc %0d", s);
    chk("t1_count", count, 49);
    chk("t1_running", running, 1);
    chk("t1_paused", paused, 0);
    wait_to(s + 151);
    drive(0, 1, 0, 0, 8'd0);
    chk("t1_paused_after_stop", paused, 1);
    chk("t1_count_held", count, 49);
    drive(0, 1, 0, 0, 8'd0);
    chk("t1_idle_count", count, 0);
    chk("t1_idle_divout", divout, 0);
    chk("t1_idle_running", running, 0);

    // Load 3 in IDLE, then run: count 3,2,1,0,3 and ticks every 4 cycles.
    drive(0, 0, 0, 1, 8'd3);
    s = cyc;
    exp_tick(s + 5, 1'b1);
    exp_tick(s + 9, 1'b0);
    exp_tick(s + 13, 1'b1);
    drive(1, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_count_seq", count, seq[i]);
      if (i < 4) nclk(1);
    end
    wait_to(s + 14);
    chk("t2_count_before_stop", count, 2);
    drive(0, 1, 0, 0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      chk("t2_pause_count", count, 2);
      chk("t2_pause_flag", paused, 1);
      nclk(1);
    end
    exp_tick(s + 29, 1'b0);
    drive(1, 0, 0, 0, 8'd0);
    chk("t2_resume_count", count, 2);
    chk("t2_resume_running", running, 1);
    wait_to(s + 30);
    drive(0, 1, 0, 0, 8'd0);
    exp_tick(s + 32, 1'b1);
    exp_tick(s + 34, 1'b0);
    exp_tick(s + 36, 1'b1);
    drive(0, 0, 1, 0, 8'd0);
    chk("t2_step_reload", count, 3);
    chk("t2_step_paused", paused, 1);
    nclk(1);
    drive(0, 0, 1, 0, 8'd0);
    nclk(1);
    drive(0, 0, 1, 0, 8'd0);
    nclk(1);
    drive(0, 1, 0, 0, 8'd0);
    chk("t2_idle_count", count, 0);
    chk("t2_idle_divout", divout, 0);
    chk("t2_idle_paused", paused, 0);

    // Mid-period load of 7: current period stays 4, later periods 8.
    s = cyc;
    exp_tick(s + 5, 1'b1);
    exp_tick(s + 9, 1'b0);
    exp_tick(s + 17, 1'b1);
    exp_tick(s + 25, 1'b0);
    drive(1, 0, 0, 0, 8'd0);
    wait_to(s + 6);
    chk("t3_count_mid", count, 2);
    drive(0, 0, 0, 1, 8'd7);
    wait_to(s + 9);
    chk("t3_reload_pending", count, 7);
    wait_to(s + 26);
    chk("t3_count_before_ss", count, 6);
    drive(1, 1, 0, 0, 8'd0);
    chk("t3_startstop_paused", paused, 1);
    chk("t3_startstop_running", running, 0);
    chk("t3_startstop_count", count, 6);
    drive(0, 1, 0, 0, 8'd0);

    // Async reset mid-run clears outputs without a clock edge.
    s = cyc;
    drive(1, 0, 0, 0, 8'd0);
    chk("t4_count_div7", count, 7);
    wait_to(s + 7);
    chk("t4_count_before_rst", count, 1);
    #2 reset = 1'b1;
    #1;
    chk("t4_async_count", count, 0);
    chk("t4_async_running", running, 0);
    chk("t4_async_tick", tick, 0);
    @(negedge hz100);
    reset = 1'b0;
    drive(1, 0, 0, 0, 8'd0);
    chk("t4_default_restored", count, 49);
    drive(0, 1, 0, 0, 8'd0);
    drive(0, 1, 0, 0, 8'd0);

    // div_in=0 loaded together with start: tick every cycle.
    s = cyc;
    exp_tick(s + 2, 1'b1);
    exp_tick(s + 3, 1'b0);
    exp_tick(s + 4, 1'b1);
    exp_tick(s + 5, 1'b0);
    drive(1, 0, 0, 1, 8'd0);
    chk("t5_loadstart_count", count, 0);
    chk("t5_running", running, 1);
    wait_to(s + 5);
    drive(0, 1, 0, 0, 8'd0);
    chk("t5_stop_no_tick", tick, 0);
    chk("t5_paused", paused, 1);
    drive(0, 1, 0, 0, 8'd0);

    nclk(3);
    while (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL tick_leftover: got no tick expected one at cyc %0d", q[0].c);
      void'(q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
